// File: rtl/control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : control_unit                                               |
// | Description : Multicycle control FSM sitting just downstream of the IR.  |
// |               Sequences FETCH -> LOAD -> DECODE -> READ -> EXEC -> WRITE |
// |               (NOP skips READ/EXEC), flags HALT and fetch timeouts, and  |
// |               counts retired instructions.                               |
// | Ports       : Clk, Rst_n (async, active low), Start, Ram_Valid, Opcode   |
// |               in; Ram_Read, IR_Load, RF_Read, Alu_En, ALU_Op, RF_Write,  |
// |               PC_Inc, Halted, Fault, Inst_Count out (all registered).    |
// | Options     : CU_SINGLE_STEP_EN adds the Step input and a PAUSE state    |
// |               entered after every WRITE, left on a Step=1 cycle.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module control_unit #(
  parameter int OPCODE_WIDTH  = 3,
  parameter int FETCH_TIMEOUT = 15,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    Start,
`ifdef CU_SINGLE_STEP_EN
  input  logic                    Step,
`endif
  input  logic                    Ram_Valid,
  input  logic [OPCODE_WIDTH-1:0] Opcode,
  output logic                    Ram_Read,
  output logic                    IR_Load,
  output logic                    RF_Read,
  output logic                    Alu_En,
  output logic [OPCODE_WIDTH-1:0] ALU_Op,
  output logic                    RF_Write,
  output logic                    PC_Inc,
  output logic                    Halted,
  output logic                    Fault,
  output logic [CNT_WIDTH-1:0]    Inst_Count
);

  localparam logic [OPCODE_WIDTH-1:0] c_op_nop  = '0;
  localparam logic [OPCODE_WIDTH-1:0] c_op_halt = '1;
  // Faulting happens on the FETCH cycle whose miss would bring the count to
  // FETCH_TIMEOUT, i.e. when the count already stands one below it.
  localparam logic [7:0]              c_tmo_last = 8'(FETCH_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_LOAD   = 4'd2,
    S_DECODE = 4'd3,
    S_READ   = 4'd4,
    S_EXEC   = 4'd5,
    S_WRITE  = 4'd6,
    S_HALT   = 4'd7,
    S_FAULT  = 4'd8
`ifdef CU_SINGLE_STEP_EN
    ,S_PAUSE = 4'd9
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              tmo_q, tmo_d;
  logic [OPCODE_WIDTH-1:0] op_q, op_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic                    ram_read_q, ram_read_d;
  logic                    ir_load_q, ir_load_d;
  logic                    rf_read_q, rf_read_d;
  logic                    alu_en_q, alu_en_d;
  logic [OPCODE_WIDTH-1:0] alu_op_q, alu_op_d;
  logic                    rf_write_q, rf_write_d;
  logic                    pc_inc_q, pc_inc_d;
  logic                    halted_q, halted_d;
  logic                    fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    op_d    = op_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE:   if (Start) state_d = S_FETCH;
      S_FETCH: begin
        if (Ram_Valid) begin
          state_d = S_LOAD;
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_q == c_tmo_last) state_d = S_FAULT;
        end
      end
      S_LOAD:   state_d = S_DECODE;
      S_DECODE: begin
        // IR output is valid this cycle; latch it for EXEC and WRITE.
        op_d = Opcode;
        if (Opcode == c_op_nop)       state_d = S_WRITE;
        else if (Opcode == c_op_halt) state_d = S_HALT;
        else                          state_d = S_READ;
      end
      S_READ:   state_d = S_EXEC;
      S_EXEC:   state_d = S_WRITE;
      S_WRITE: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
`ifdef CU_SINGLE_STEP_EN
        state_d = S_PAUSE;
`else
        state_d = S_FETCH;
`endif
      end
`ifdef CU_SINGLE_STEP_EN
      S_PAUSE:  if (Step) state_d = S_FETCH;
`endif
      S_HALT:   state_d = S_HALT;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase

    // Moore outputs are decoded from the next state so that, once
    // registered, they line up with the state they belong to.
    ram_read_d = (state_d == S_FETCH);
    ir_load_d  = (state_d == S_LOAD);
    rf_read_d  = (state_d == S_READ);
    alu_en_d   = (state_d == S_EXEC);
    alu_op_d   = (state_d == S_EXEC) ? op_d : '0;
    rf_write_d = (state_d == S_WRITE) && (op_d != c_op_nop);
    pc_inc_d   = (state_d == S_WRITE);
    halted_d   = (state_d == S_HALT);
    fault_d    = (state_d == S_FAULT);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      tmo_q      <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      ram_read_q <= 1'b0;
      ir_load_q  <= 1'b0;
      rf_read_q  <= 1'b0;
      alu_en_q   <= 1'b0;
      alu_op_q   <= '0;
      rf_write_q <= 1'b0;
      pc_inc_q   <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      ram_read_q <= ram_read_d;
      ir_load_q  <= ir_load_d;
      rf_read_q  <= rf_read_d;
      alu_en_q   <= alu_en_d;
      alu_op_q   <= alu_op_d;
      rf_write_q <= rf_write_d;
      pc_inc_q   <= pc_inc_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  assign Ram_Read   = ram_read_q;
  assign IR_Load    = ir_load_q;
  assign RF_Read    = rf_read_q;
  assign Alu_En     = alu_en_q;
  assign ALU_Op     = alu_op_q;
  assign RF_Write   = rf_write_q;
  assign PC_Inc     = pc_inc_q;
  assign Halted     = halted_q;
  assign Fault      = fault_q;
  assign Inst_Count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_control_unit                                            |
// | Description : Self-checking bench for control_unit. Expected per-cycle   |
// |               outputs are derived from an instruction-level model (wait  |
// |               cycles + opcode -> list of phases) and compared each cycle.|
// |               A second instance with a 4-bit counter checks wrapping.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, ram_valid;
  logic [2:0] opcode;
`ifdef CU_SINGLE_STEP_EN
  logic       step;
`endif
  logic        ram_read, ir_load, rf_read, alu_en, rf_write, pc_inc, halted, fault;
  logic [2:0]  alu_op;
  logic [15:0] inst_count;

  logic        rst4_n, start4;
  logic        ram_read4, ir_load4, rf_read4, alu_en4, rf_write4, pc_inc4, halted4, fault4;
  logic [2:0]  alu_op4;
  logic [3:0]  inst_count4;

  control_unit dut (
    .Clk(clk), .Rst_n(rst_n), .Start(start),
`ifdef CU_SINGLE_STEP_EN
    .Step(step),
`endif
    .Ram_Valid(ram_valid), .Opcode(opcode),
    .Ram_Read(ram_read), .IR_Load(ir_load), .RF_Read(rf_read), .Alu_En(alu_en),
    .ALU_Op(alu_op), .RF_Write(rf_write), .PC_Inc(pc_inc), .Halted(halted),
    .Fault(fault), .Inst_Count(inst_count)
  );

  control_unit #(.CNT_WIDTH(4)) dut4 (
    .Clk(clk), .Rst_n(rst4_n), .Start(start4),
`ifdef CU_SINGLE_STEP_EN
    .Step(step),
`endif
    .Ram_Valid(ram_valid), .Opcode(opcode),
    .Ram_Read(ram_read4), .IR_Load(ir_load4), .RF_Read(rf_read4), .Alu_En(alu_en4),
    .ALU_Op(alu_op4), .RF_Write(rf_write4), .PC_Inc(pc_inc4), .Halted(halted4),
    .Fault(fault4), .Inst_Count(inst_count4)
  );

  typedef struct packed {
    logic rr, irl, rfr, alu;
    logic [2:0] aop;
    logic rfw, pci, hlt, flt;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic       start, rv, stp;
    logic [2:0] op;
    exp_t       e;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   retired = 0;
  vec_t q[$];
  vec_t tbl[7];

  function automatic exp_t mk(bit rr, bit irl, bit rfr, bit alu, int aop,
                              bit rfw, bit pci, bit hlt, bit flt, int cnt);
    exp_t e;
    e.rr = rr; e.irl = irl; e.rfr = rfr; e.alu = alu; e.aop = 3'(aop);
    e.rfw = rfw; e.pci = pci; e.hlt = hlt; e.flt = flt; e.cnt = 16'(cnt);
    return e;
  endfunction

  function automatic vec_t mkv(bit st, bit rv, bit stp, int op, exp_t e);
    vec_t v;
    v.start = st; v.rv = rv; v.stp = stp; v.op = 3'(op); v.e = e;
    return v;
  endfunction

  function automatic exp_t obs();
    exp_t e;
    e.rr = ram_read; e.irl = ir_load; e.rfr = rf_read; e.alu = alu_en; e.aop = alu_op;
    e.rfw = rf_write; e.pci = pc_inc; e.hlt = halted; e.flt = fault; e.cnt = inst_count;
    return e;
  endfunction

  function automatic string fmt(exp_t e);
    return $sformatf("rr=%b irl=%b rfr=%b alu=%b aop=%0d rfw=%b pci=%b hlt=%b flt=%b cnt=%0d",
                     e.rr, e.irl, e.rfr, e.alu, e.aop, e.rfw, e.pci, e.hlt, e.flt, e.cnt);
  endfunction

  task automatic check(input string nm, input exp_t e);
    exp_t a;
    a = obs();
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s @%0t: got {%s} want {%s}", nm, $time, fmt(a), fmt(e));
    end
  endtask

  task automatic push(input bit st, input bit rv, input bit stp, input int op, input exp_t e);
    q.push_back(mkv(st, rv, stp, op, e));
  endtask

  // Called at posedge+1; drives one cycle, checks mid-cycle, returns at posedge+1.
  task automatic apply(input vec_t v, input string nm);
    start = v.start; ram_valid = v.rv; opcode = v.op;
`ifdef CU_SINGLE_STEP_EN
    step = v.stp;
`endif
    @(negedge clk);
    check(nm, v.e);
    @(posedge clk); #1;
  endtask

  task automatic run_queue(input string nm);
    while (q.size() > 0) apply(q.pop_front(), nm);
  endtask

  task automatic after_write();
`ifdef CU_SINGLE_STEP_EN
    int n;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++)
      push($urandom_range(0, 1), 1, 0, $urandom_range(0, 7), mk(0,0,0,0,0,0,0,0,0, retired));
    push(0, 1, 1, 0, mk(0,0,0,0,0,0,0,0,0, retired));
`endif
  endtask

  // One instruction from FETCH: wait_n invalid fetch cycles, then the phases
  // its opcode class calls for.
  task automatic gen_instr(input int op, input int wait_n);
    for (int i = 0; i < wait_n; i++) push(0, 0, 0, op, mk(1,0,0,0,0,0,0,0,0, retired));
    push(0, 1, 0, op, mk(1,0,0,0,0,0,0,0,0, retired));
    push(0, 0, 0, op, mk(0,1,0,0,0,0,0,0,0, retired));
    push(0, 0, 0, op, mk(0,0,0,0,0,0,0,0,0, retired));
    if (op == 7) begin
      for (int i = 0; i < 5; i++)
        push($urandom_range(0, 1), 1, 1, op, mk(0,0,0,0,0,0,0,1,0, retired));
      return;
    end
    if (op != 0) begin
      push(0, 0, 0, op, mk(0,0,1,0,0,0,0,0,0, retired));
      push(0, 0, 0, op, mk(0,0,0,1,op,0,0,0,0, retired));
    end
    push(0, 0, 0, op, mk(0,0,0,0,0, op != 0, 1, 0, 0, retired));
    retired = (retired + 1) % 65536;
    after_write();
  endtask

  task automatic reset_pulse(input string nm);
    rst_n = 1'b0;
    #1;
    check(nm, mk(0,0,0,0,0,0,0,0,0,0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    retired = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed ADD from IDLE with Ram_Valid high immediately.
    tbl[0] = mkv(1, 0, 0, 1, mk(0,0,0,0,0,0,0,0,0,0));
    tbl[1] = mkv(0, 1, 0, 1, mk(1,0,0,0,0,0,0,0,0,0));
    tbl[2] = mkv(0, 0, 0, 1, mk(0,1,0,0,0,0,0,0,0,0));
    tbl[3] = mkv(0, 0, 0, 1, mk(0,0,0,0,0,0,0,0,0,0));
    tbl[4] = mkv(0, 0, 0, 1, mk(0,0,1,0,0,0,0,0,0,0));
    tbl[5] = mkv(0, 0, 0, 1, mk(0,0,0,1,1,0,0,0,0,0));
    tbl[6] = mkv(0, 0, 0, 1, mk(0,0,0,0,0,1,1,0,0,0));

    rst_n = 1'b0; start = 1'b0; ram_valid = 1'b0; opcode = 3'd0;
    rst4_n = 1'b0; start4 = 1'b0;
`ifdef CU_SINGLE_STEP_EN
    step = 1'b0;
`endif
    #12;
    check("reset_state", mk(0,0,0,0,0,0,0,0,0,0));
    n_cmp++;
    if (inst_count4 !== 4'd0) begin
      n_err++;
      $display("FAIL reset_cnt4: got %0d want 0", inst_count4);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) apply(tbl[i], $sformatf("table[%0d]", i));
    retired = 1;
    after_write();
    gen_instr(0, 0);
    run_queue("nop");

    for (int n = 0; n < 60; n++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
      gen_instr($urandom_range(0, 6), w);
    end
    run_queue("random");

    // Async reset in the middle of EXEC.
    push(0, 1, 0, 1, mk(1,0,0,0,0,0,0,0,0, retired));
    push(0, 0, 0, 1, mk(0,1,0,0,0,0,0,0,0, retired));
    push(0, 0, 0, 1, mk(0,0,0,0,0,0,0,0,0, retired));
    push(0, 0, 0, 1, mk(0,0,1,0,0,0,0,0,0, retired));
    run_queue("to_exec");
    check("in_exec", mk(0,0,0,1,1,0,0,0,0, retired));
    #2 rst_n = 1'b0;
    #1 check("async_rst_exec", mk(0,0,0,0,0,0,0,0,0,0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    retired = 0;

    // Restart, two ADDs then HALT; Start ignored while halted.
    push(0, 1, 0, 1, mk(0,0,0,0,0,0,0,0,0,0));
    push(1, 0, 0, 1, mk(0,0,0,0,0,0,0,0,0,0));
    gen_instr(1, 0);
    gen_instr(1, 1);
    gen_instr(7, 0);
    run_queue("halt_seq");
    reset_pulse("halt_reset");

    // Fetch timeout: 15 misses fault on the 16th cycle, fault is sticky.
    push(1, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 15; i++) push(0, 0, 0, 0, mk(1,0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 4; i++) push(1, 1, 1, 1, mk(0,0,0,0,0,0,0,0,1,0));
    run_queue("timeout");
    reset_pulse("fault_reset");

    // Valid on the 15th fetch cycle wins over the timeout.
    push(1, 0, 0, 2, mk(0,0,0,0,0,0,0,0,0,0));
    gen_instr(2, 14);
    gen_instr(0, 0);
    run_queue("valid_at_limit");

    // 4-bit counter instance: 17 NOPs wrap 15 -> 0 -> 1.
    ram_valid = 1'b1; opcode = 3'd0;
`ifdef CU_SINGLE_STEP_EN
    step = 1'b1;
`endif
    rst4_n = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      int b;
      b = 0;
      while (inst_count4 !== 4'(k % 16) && b < 40) begin
        @(posedge clk); #1;
        b++;
      end
      n_cmp++;
      if (inst_count4 !== 4'(k % 16)) begin
        n_err++;
        $display("FAIL wrap_nop%0d: got %0d want %0d", k, inst_count4, k % 16);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle control FSM placed directly downstream of the instruction register (IR).
- Sequences fetch, IR load, decode, register read, ALU execute, writeback and PC increment.
- Consumes the IR's 3-bit Opcode field; drives IR_Load back to the IR, plus the RAM read handshake and the register-file, ALU and PC strobes.
- Flags HALT and fetch-timeout faults, and counts retired instructions.

Parameters:
- OPCODE_WIDTH, 3: width of Opcode, matching IR bits [20:18].
- FETCH_TIMEOUT, 15: maximum FETCH cycles allowed without Ram_Valid before faulting; legal range 1..255.
- CNT_WIDTH, 16: width of the retired-instruction counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Start  in  1  begin execution; honoured only in IDLE.
- Ram_Valid  in  1  RAM instruction word valid on Ram_Inst_Out.
- Opcode  in  OPCODE_WIDTH  opcode from the IR.
- Ram_Read  out  1  instruction read request.
- IR_Load  out  1  IR capture strobe.
- RF_Read  out  1  register-file read of Source_Reg1/Source_Reg2.
- Alu_En  out  1  ALU operation strobe.
- ALU_Op  out  OPCODE_WIDTH  ALU operation code.
- RF_Write  out  1  register-file write to Dest_Reg.
- PC_Inc  out  1  program counter increment.
- Halted  out  1  HALT instruction reached.
- Fault  out  1  fetch timeout occurred.
- Inst_Count  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- Reset: Rst_n low asynchronously forces state IDLE, timeout counter 0, Op_q 0, Inst_Count 0, and every output 0. This holds mid-instruction and in HALT or FAULT.
- All control outputs are registered Moore outputs decoded from the state.
- Opcodes:
  - 000 NOP.
  - 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 PASS (ALU class).
  - 111 HALT.
- IDLE: all outputs 0. Start=1 -> FETCH. Start is ignored in every other state.
- FETCH:
  - Ram_Read=1.
  - Timeout counter increments each FETCH cycle in which Ram_Valid=0.
  - Ram_Valid=1 -> LOAD, counter cleared.
  - Counter reaching FETCH_TIMEOUT with Ram_Valid=0 -> FAULT.
  - Ram_Valid=1 on the cycle the limit would be reached: valid wins.
- LOAD: IR_Load=1 for exactly one cycle -> DECODE.
- DECODE: Opcode is sampled into Op_q (the IR output is valid this cycle). Next state:
  - 000 -> WRITE.
  - 111 -> HALT.
  - otherwise -> READ.
- READ: RF_Read=1 -> EXEC.
- EXEC: Alu_En=1, ALU_Op=Op_q -> WRITE. ALU_Op is 000 in every other state.
- WRITE:
  - PC_Inc=1.
  - RF_Write=1 unless Op_q=000.
  - Inst_Count increments, wrapping from 2^CNT_WIDTH-1 to 0.
  - Next state FETCH.
- HALT: Halted=1, sticky. No PC_Inc and no count. Exit only by reset.
- FAULT: Fault=1, sticky. All strobes 0. Exit only by reset.
- Latency with Ram_Valid high on the first FETCH cycle: ALU instruction 6 cycles FETCH-to-FETCH; NOP 4 cycles.
- At most one of Ram_Read, IR_Load, RF_Read, Alu_En, RF_Write is high in any cycle.

Optional Feature:
- Macro CU_SINGLE_STEP_EN.
- Defined:
  - Adds input port Step (1 bit).
  - WRITE goes to state PAUSE instead of FETCH. PAUSE has all strobes 0.
  - A Step=1 cycle in PAUSE -> FETCH next cycle.
  - Step is ignored in other states.
  - Reset in PAUSE -> IDLE.
- Undefined: no Step port and no PAUSE state; WRITE goes directly to FETCH.

Test Plan:
- Reset, then pulse Start; Ram_Valid=1 immediately; Opcode=001 -> Ram_Read, IR_Load, RF_Read, Alu_En (ALU_Op=001), RF_Write+PC_Inc on consecutive cycles; Inst_Count=1 after 6 cycles.
- NOP (Opcode=000) -> LOAD, DECODE, then WRITE with PC_Inc=1 and RF_Write=0; RF_Read and Alu_En never high; Inst_Count increments.
- Ram_Valid held 0 for FETCH_TIMEOUT=15 cycles -> Fault=1 on cycle 16 and stays 1; Ram_Valid=1 exactly on cycle 15 -> LOAD, no Fault.
- Opcode=111 after two ADDs -> Halted=1, Inst_Count=2, no further Ram_Read; Start has no effect; Rst_n low clears Halted and Inst_Count.
- Rst_n dropped asynchronously during EXEC -> Alu_En and ALU_Op drop to 0 before the next clock edge; state IDLE after release; Start restarts at FETCH.
- CNT_WIDTH=4, run 17 NOPs -> Inst_Count wraps 15 -> 0 -> 1; with CU_SINGLE_STEP_EN, the FSM parks in PAUSE after each WRITE until a Step pulse.
